// File: rtl/branch_predictor_pkg.sv
// rtl/branch_predictor_pkg.sv - shared widths, defaults and counter encodings for the branch predictor
package branch_predictor_pkg;

  localparam int PC_WIDTH    = 32;
  localparam int BP_IDX_BITS = 6;
  localparam int BP_GHR_BITS = 6;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

endpackage

// File: rtl/branch_predictor_if.sv
// rtl/branch_predictor_if.sv - fetch lookup and decode training bundle; master is the pipeline, slave the predictor
interface branch_predictor_if
  import branch_predictor_pkg::*;
#(
  parameter int PCW  = PC_WIDTH,
  parameter int GHRW = BP_GHR_BITS
);
  logic            f_valid;
  logic [PCW-1:0]  f_pc;
  logic            f_pred_taken;
  logic [PCW-1:0]  f_pred_pc;
  logic [GHRW-1:0] f_pred_ghr;
  logic            dd_train_valid;
  logic            dd_train_taken;
  logic [PCW-1:0]  dd_train_pc;
  logic [PCW-1:0]  dd_train_target;
  logic [GHRW-1:0] dd_train_ghr;
  logic            dd_mispred;
  logic [31:0]     mispred_cnt;

  modport master (
    output f_valid, f_pc, dd_train_valid, dd_train_taken, dd_train_pc,
           dd_train_target, dd_train_ghr, dd_mispred,
    input  f_pred_taken, f_pred_pc, f_pred_ghr, mispred_cnt
  );

  modport slave (
    input  f_valid, f_pc, dd_train_valid, dd_train_taken, dd_train_pc,
           dd_train_target, dd_train_ghr, dd_mispred,
    output f_pred_taken, f_pred_pc, f_pred_ghr, mispred_cnt
  );
endinterface

// File: rtl/branch_predictor_sat_counter.sv
// rtl/branch_predictor_sat_counter.sv - 2-bit saturating counter next-state for BHT training
module branch_predictor_sat_counter
  import branch_predictor_pkg::*;
(
  input  ctr_e ctr,
  input  logic taken,
  output ctr_e next
);
  always_comb begin
    next = ctr;
    case (ctr)
      SNT:     next = taken ? WNT : SNT;
      WNT:     next = taken ? WT  : SNT;
      WT:      next = taken ? ST  : WNT;
      ST:      next = taken ? ST  : WT;
      default: next = ctr;
    endcase
  end
endmodule

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - BHT + direct-mapped BTB fetch predictor; BP_GSHARE_EN adds global-history BHT hashing
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int IDX_BITS = BP_IDX_BITS,
  parameter int GHR_BITS = BP_GHR_BITS
)(
  input logic clk,
  input logic rst_n,
  branch_predictor_if.slave bus
);
  localparam int ENTRIES  = 1 << IDX_BITS;
  localparam int TAG_BITS = PC_WIDTH - IDX_BITS - 2;

  ctr_e                bht        [ENTRIES];
  logic                btb_valid  [ENTRIES];
  logic [TAG_BITS-1:0] btb_tag    [ENTRIES];
  logic [PC_WIDTH-1:0] btb_target [ENTRIES];
  logic [31:0]         mispred_cnt;

  logic [IDX_BITS-1:0] f_idx, f_bht_idx, t_idx, t_bht_idx;
  logic [TAG_BITS-1:0] f_tag, t_tag;
  logic                hit, taken;
  ctr_e                ctr_next;

  assign f_idx = bus.f_pc[IDX_BITS+1:2];
  assign f_tag = bus.f_pc[PC_WIDTH-1:IDX_BITS+2];
  assign t_idx = bus.dd_train_pc[IDX_BITS+1:2];
  assign t_tag = bus.dd_train_pc[PC_WIDTH-1:IDX_BITS+2];

`ifdef BP_GSHARE_EN
  logic [GHR_BITS-1:0] ghr;

  assign f_bht_idx      = f_idx ^ IDX_BITS'(ghr);
  assign t_bht_idx      = t_idx ^ IDX_BITS'(bus.dd_train_ghr);
  assign bus.f_pred_ghr = ghr;

  // Decode repair wins over the speculative fetch shift in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ghr <= '0;
    end else if (bus.dd_train_valid && bus.dd_mispred) begin
      ghr <= {bus.dd_train_ghr[GHR_BITS-2:0], bus.dd_train_taken};
    end else if (bus.f_valid && hit) begin
      ghr <= {ghr[GHR_BITS-2:0], taken};
    end
  end
`else
  assign f_bht_idx      = f_idx;
  assign t_bht_idx      = t_idx;
  assign bus.f_pred_ghr = GHR_BITS'(0);
`endif

  assign hit              = btb_valid[f_idx] && (btb_tag[f_idx] == f_tag);
  assign taken            = hit && bht[f_bht_idx][1];
  assign bus.f_pred_taken = taken;
  assign bus.f_pred_pc    = taken ? btb_target[f_idx] : bus.f_pc + PC_WIDTH'(4);
  assign bus.mispred_cnt  = mispred_cnt;

  branch_predictor_sat_counter u_sat (
    .ctr   (bht[t_bht_idx]),
    .taken (bus.dd_train_taken),
    .next  (ctr_next)
  );

  // Lookup reads the arrays combinationally, so a same-cycle train is seen only next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        bht[i]        <= WNT;
        btb_valid[i]  <= 1'b0;
        btb_tag[i]    <= '0;
        btb_target[i] <= '0;
      end
      mispred_cnt <= '0;
    end else if (bus.dd_train_valid) begin
      bht[t_bht_idx] <= ctr_next;
      if (bus.dd_train_taken) begin
        btb_valid[t_idx]  <= 1'b1;
        btb_tag[t_idx]    <= t_tag;
        btb_target[t_idx] <= bus.dd_train_target;
      end
      if (bus.dd_mispred) begin
        mispred_cnt <= mispred_cnt + 32'd1;
      end
    end
  end
endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - randomized self-checking bench for branch_predictor against a table model
module tb_branch_predictor;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  branch_predictor_if bus ();
  branch_predictor dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int vectors = 0;
  int miscompares = 0;

  int          m_ctr [64];
  bit          m_val [64];
  logic [31:0] m_tag [64];
  logic [31:0] m_tgt [64];
  logic [31:0] m_cnt;
  logic [5:0]  m_ghr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) begin
      m_ctr[i] = 1; m_val[i] = 0; m_tag[i] = '0; m_tgt[i] = '0;
    end
    m_cnt = '0;
    m_ghr = '0;
  endtask

  function automatic int pc_idx(input logic [31:0] pc);
    return int'((pc >> 2) % 64);
  endfunction

  function automatic int bht_idx(input logic [31:0] pc, input logic [5:0] g);
`ifdef BP_GSHARE_EN
    return pc_idx(pc) ^ int'(g);
`else
    return pc_idx(pc) + 0 * int'(g);
`endif
  endfunction

  // One clock: drive, check the pre-edge lookup, then advance the model across the edge.
  task automatic cycle(input logic fv, input logic [31:0] fpc, input logic tv, input logic tt,
                       input logic [31:0] tpc, input logic [31:0] ttgt, input logic mp,
                       input logic [5:0] tghr);
    bit          hit;
    bit          e_taken;
    logic [31:0] e_pc;
    int          ti, tb_i;
    bus.f_valid = fv; bus.f_pc = fpc;
    bus.dd_train_valid = tv; bus.dd_train_taken = tt; bus.dd_train_pc = tpc;
    bus.dd_train_target = ttgt; bus.dd_mispred = mp; bus.dd_train_ghr = tghr;
    #1;
    hit     = m_val[pc_idx(fpc)] && (m_tag[pc_idx(fpc)] == (fpc >> 8));
    e_taken = hit && (m_ctr[bht_idx(fpc, m_ghr)] >= 2);
    e_pc    = e_taken ? m_tgt[pc_idx(fpc)] : fpc + 32'd4;
    check("pred_taken", 32'(bus.f_pred_taken), 32'(e_taken));
    check("pred_pc", bus.f_pred_pc, e_pc);
    check("pred_ghr", 32'(bus.f_pred_ghr), 32'(m_ghr));
    check("mispred_cnt", bus.mispred_cnt, m_cnt);
    @(posedge clk);
    if (tv) begin
      ti   = pc_idx(tpc);
      tb_i = bht_idx(tpc, tghr);
      m_ctr[tb_i] = tt ? ((m_ctr[tb_i] < 3) ? m_ctr[tb_i] + 1 : 3)
                       : ((m_ctr[tb_i] > 0) ? m_ctr[tb_i] - 1 : 0);
      if (tt) begin
        m_val[ti] = 1; m_tag[ti] = tpc >> 8; m_tgt[ti] = ttgt;
      end
      if (mp) m_cnt = m_cnt + 1;
    end
`ifdef BP_GSHARE_EN
    if (tv && mp) m_ghr = {tghr[4:0], tt};
    else if (fv && hit) m_ghr = {m_ghr[4:0], e_taken};
`endif
    @(negedge clk);
  endtask

  task automatic train(input logic tt, input logic [31:0] tpc, input logic [31:0] ttgt);
    cycle(1'b0, 32'h0, 1'b1, tt, tpc, ttgt, 1'b0, m_ghr);
  endtask

  task automatic lookup(input logic [31:0] fpc);
    cycle(1'b1, fpc, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 6'h0);
  endtask

  function automatic logic [31:0] rand_pc();
    return ($urandom_range(0, 3) << 12) | ($urandom_range(0, 15) << 2);
  endfunction

  initial begin
    logic [31:0] pc;
    bus.f_valid = 0; bus.f_pc = 32'h8000_0010;
    bus.dd_train_valid = 0; bus.dd_train_taken = 0; bus.dd_train_pc = 0;
    bus.dd_train_target = 0; bus.dd_mispred = 0; bus.dd_train_ghr = 0;
    model_reset();
    #12 rst_n = 1'b1;
    @(negedge clk);

    // Reset state: no hit, fall-through PC, zero count.
    check("reset_taken", 32'(bus.f_pred_taken), 32'h0);
    check("reset_pred_pc", bus.f_pred_pc, 32'h8000_0014);
    check("reset_cnt", bus.mispred_cnt, 32'h0);
    lookup(32'h8000_0010);

    train(1, 32'h100, 32'h200);
    train(1, 32'h100, 32'h200);
    lookup(32'h100);
    for (int i = 0; i < 4; i++) train(0, 32'h100, 32'h0);
    lookup(32'h100);
    train(1, 32'h100, 32'h200);
    lookup(32'h1100);
    cycle(1, 32'h100, 1, 1, 32'h100, 32'h200, 0, m_ghr);
    lookup(32'h100);
    lookup(32'hFFFF_FFFC);

    // Disabled train must not move tables or the counter even with mispred high.
    cycle(1, 32'h100, 0, 0, 32'h100, 32'h300, 1, 6'h0);
    lookup(32'h100);

    for (int n = 0; n < 300; n++) begin
      pc = rand_pc();
      cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 1) != 0) ? pc : rand_pc(),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), pc,
            $urandom & 32'hFFFF_FFFC, 1'($urandom_range(0, 1)), 6'($urandom));
    end

    // Counter wrap.
    force dut.mispred_cnt = 32'hFFFF_FFFE;
    #1 release dut.mispred_cnt;
    m_cnt = 32'hFFFF_FFFE;
    cycle(0, 32'h0, 1, 1, 32'h40, 32'h80, 1, 6'b000111);
    cycle(0, 32'h0, 1, 0, 32'h40, 32'h80, 1, 6'b000111);
    cycle(1, 32'h40, 1, 1, 32'h44, 32'h88, 1, 6'b000111);
    check("cnt_wrapped", bus.mispred_cnt, 32'h1);

    // Asynchronous reset mid-cycle clears everything.
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("async_rst_cnt", bus.mispred_cnt, 32'h0);
    bus.f_pc = 32'h100;
    #1;
    check("async_rst_taken", 32'(bus.f_pred_taken), 32'h0);
    check("async_rst_pc", bus.f_pred_pc, 32'h104);
    @(negedge clk);
    rst_n = 1'b1;
    lookup(32'h100);
    lookup(32'h40);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
